lc3_program_loader: RTL and testbench

Byte-stream program loader directly upstream of the LC3 `datapath`. It holds the CPU in reset and receives an object image one byte at a time, for example from a UART receiver. It writes each 16-bit word into main memory through a dedicated write port and checks an XOR checksum. On a good image it releases the CPU reset; on a bad or stalled image it holds the CPU in reset and flags an error.

---
 rtl/lc3_program_loader.sv | 208 ++++++++++++++++++++
 tb/tb_lc3_program_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_program_loader.sv
// Byte-stream object-image loader for the LC3: writes ORIGIN/COUNT/DATA words into
// memory, verifies the trailing XOR checksum and releases the CPU reset on success.
module lc3_program_loader #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        i_CLK,
  input  logic        i_Reset_n,
  input  logic [7:0]  i_Byte,
  input  logic        i_Byte_Valid,
  input  logic        i_Restart,
  output logic [15:0] o_Mem_Addr,
  output logic [15:0] o_Mem_Data,
  output logic        o_Mem_WE,
  output logic        o_CPU_Reset,
  output logic [15:0] o_Start_PC,
  output logic        o_Done,
  output logic        o_Error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The byte-free cycle that would bring the counter to TIMEOUT_CYCLES aborts the load.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ORG_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    org_hi_q, org_hi_d;
  logic [7:0]    cnt_hi_q, cnt_hi_d;
  logic [7:0]    data_hi_q, data_hi_d;
  logic [15:0]   words_q, words_d;
  logic [15:0]   addr_ptr_q, addr_ptr_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic [15:0]   start_pc_q, start_pc_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic loading;
  logic accept;

  always_ff @(posedge i_CLK or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= S_IDLE;
      org_hi_q    <= '0;
      cnt_hi_q    <= '0;
      data_hi_q   <= '0;
      words_q     <= '0;
      addr_ptr_q  <= '0;
      xor_q       <= '0;
      tmo_q       <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      start_pc_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      org_hi_q    <= org_hi_d;
      cnt_hi_q    <= cnt_hi_d;
      data_hi_q   <= data_hi_d;
      words_q     <= words_d;
      addr_ptr_q  <= addr_ptr_d;
      xor_q       <= xor_d;
      tmo_q       <= tmo_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      cpu_reset_q <= cpu_reset_d;
      start_pc_q  <= start_pc_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    org_hi_d    = org_hi_q;
    cnt_hi_d    = cnt_hi_q;
    data_hi_d   = data_hi_q;
    words_d     = words_q;
    addr_ptr_d  = addr_ptr_q;
    xor_d       = xor_q;
    tmo_d       = tmo_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_we_d    = 1'b0;
    cpu_reset_d = cpu_reset_q;
    start_pc_d  = start_pc_q;
    done_d      = done_q;
    error_d     = error_q;

    loading = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    accept  = i_Byte_Valid && (state_q != S_DONE) && (state_q != S_ERROR);

    if (loading) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (accept) begin
      tmo_d = '0;
      if (state_q != S_CHK) begin
        xor_d = xor_q ^ i_Byte;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          org_hi_d = i_Byte;
          state_d  = S_ORG_LO;
        end
      end
      S_ORG_LO: begin
        if (accept) begin
          start_pc_d = {org_hi_q, i_Byte};
          addr_ptr_d = {org_hi_q, i_Byte};
          state_d    = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_hi_d = i_Byte;
          state_d  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          words_d = {cnt_hi_q, i_Byte};
          state_d = ({cnt_hi_q, i_Byte} == 16'h0000) ? S_CHK : S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          data_hi_d = i_Byte;
          state_d   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          // Address pointer wraps naturally in 16 bits past 0xFFFF.
          mem_we_d   = 1'b1;
          mem_addr_d = addr_ptr_q;
          mem_data_d = {data_hi_q, i_Byte};
          addr_ptr_d = addr_ptr_q + 16'd1;
          words_d    = words_q - 16'd1;
          state_d    = (words_q == 16'd1) ? S_CHK : S_DATA_HI;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (i_Byte == xor_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (i_Restart) begin
          state_d     = S_IDLE;
          done_d      = 1'b0;
          error_d     = 1'b0;
          cpu_reset_d = 1'b1;
          start_pc_d  = '0;
          xor_d       = '0;
          tmo_d       = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A byte arriving in the same cycle as the timeout keeps the load alive.
    if (loading && !i_Byte_Valid && (tmo_q == TMO_LAST)) begin
      state_d = S_ERROR;
      error_d = 1'b1;
      tmo_d   = '0;
    end
  end

  assign o_Mem_Addr  = mem_addr_q;
  assign o_Mem_Data  = mem_data_q;
  assign o_Mem_WE    = mem_we_q;
  assign o_CPU_Reset = cpu_reset_q;
  assign o_Start_PC  = start_pc_q;
  assign o_Done      = done_q;
  assign o_Error     = error_q;

endmodule

// File: tb/tb_lc3_program_loader.sv
// Randomized self-checking bench for lc3_program_loader against an image-level model.
module tb_lc3_program_loader;

  typedef logic [15:0] word_q_t[$];

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        restart;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_reset;
  logic [15:0] start_pc;
  logic        done;
  logic        error;

  int checks;
  int errors;
  logic [31:0] wr_q[$];

  lc3_program_loader #(.TIMEOUT_CYCLES(16)) dut (
    .i_CLK        (clk),
    .i_Reset_n    (rst_n),
    .i_Byte       (byte_in),
    .i_Byte_Valid (byte_valid),
    .i_Restart    (restart),
    .o_Mem_Addr   (mem_addr),
    .o_Mem_Data   (mem_data),
    .o_Mem_WE     (mem_we),
    .o_CPU_Reset  (cpu_reset),
    .o_Start_PC   (start_pc),
    .o_Done       (done),
    .o_Error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with a write strobe is one memory write; pulses longer than one cycle show up as extras.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_data});
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Build the image from origin/words, send it, and compare against the model's expectations.
  task automatic run_load(input logic [15:0] org, input word_q_t words, input bit use_chk,
                          input logic [7:0] chk_in, input int max_gap);
    logic [7:0]  img[$];
    logic [7:0]  x;
    logic [7:0]  chk;
    logic [15:0] a;
    logic [31:0] exp_w[$];
    logic [15:0] n;
    bit          good;
    n = 16'(words.size());
    img = {};
    img.push_back(org[15:8]); img.push_back(org[7:0]);
    img.push_back(n[15:8]);   img.push_back(n[7:0]);
    foreach (words[i]) begin
      img.push_back(words[i][15:8]);
      img.push_back(words[i][7:0]);
      a = org + 16'(i);
      exp_w.push_back({a, words[i]});
    end
    x = 8'h00;
    foreach (img[i]) x = x ^ img[i];
    chk  = use_chk ? chk_in : x;
    good = (chk == x);
    $display("load org=%h count=%0d chk=%h expect_%s", org, words.size(), chk, good ? "done" : "error");
    wr_q.delete();
    foreach (img[i]) begin
      send_byte(img[i]);
      if (i == 1) begin
        checks++;
        if (start_pc !== org) begin
          errors++;
          $display("FAIL start_pc_after_org: got %h want %h", start_pc, org);
        end
      end
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    send_byte(chk);
    checks++;
    if (done !== good || error !== !good || cpu_reset !== !good) begin
      errors++;
      $display("FAIL load_status: got done=%b error=%b cpu_reset=%b want done=%b error=%b cpu_reset=%b",
               done, error, cpu_reset, good, !good, !good);
    end
    checks++;
    if (start_pc !== org) begin
      errors++;
      $display("FAIL start_pc_held: got %h want %h", start_pc, org);
    end
    checks++;
    if (wr_q.size() != exp_w.size()) begin
      errors++;
      $display("FAIL write_count: got %0d want %0d", wr_q.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        checks++;
        if (wr_q[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL write_%0d: got addr=%h data=%h want addr=%h data=%h",
                   i, wr_q[i][31:16], wr_q[i][15:0], exp_w[i][31:16], exp_w[i][15:0]);
        end
      end
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || start_pc !== 16'h0000) begin
      errors++;
      $display("FAIL restart: got cpu_reset=%b done=%b error=%b start_pc=%h want 1 0 0 0000",
               cpu_reset, done, error, start_pc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; restart = 1'b0;
    idle(2);
    checks++;
    if (mem_addr !== 16'h0 || mem_data !== 16'h0 || mem_we !== 1'b0 || cpu_reset !== 1'b1 ||
        start_pc !== 16'h0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got addr=%h data=%h we=%b cpu_reset=%b pc=%h done=%b error=%b",
               mem_addr, mem_data, mem_we, cpu_reset, start_pc, done, error);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_load();
    word_q_t w;
    w = '{16'h0005, 16'h0002, 16'h0009};
    run_load(16'h3250, w, 1'b1, 8'h6F, 0);
    checks++;
    if (mem_addr !== 16'h3252 || mem_data !== 16'h0009 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got addr=%h data=%h we=%b want 3252 0009 0", mem_addr, mem_data, mem_we);
    end
  endtask

  task automatic test_ignored_bytes();
    wr_q.delete();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    checks++;
    if (done !== 1'b1 || start_pc !== 16'h3250 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL done_ignores_bytes: got done=%b pc=%h writes=%0d want 1 3250 0", done, start_pc, wr_q.size());
    end
  endtask

  task automatic test_restart_collision();
    word_q_t w;
    restart = 1'b1; byte_in = 8'h32; byte_valid = 1'b1;
    @(negedge clk);
    restart = 1'b0; byte_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL restart_wins: got done=%b cpu_reset=%b want 0 1", done, cpu_reset);
    end
    w = '{16'h0005, 16'h0002, 16'h0009};
    run_load(16'h3250, w, 1'b1, 8'h6F, 0);
    do_restart();
  endtask

  task automatic test_addr_wrap();
    word_q_t w;
    w = '{16'h1234, 16'hABCD};
    run_load(16'hFFFF, w, 1'b0, 8'h00, 0);
    do_restart();
  endtask

  task automatic test_zero_count();
    word_q_t w;
    w = {};
    run_load(16'h3000, w, 1'b1, 8'h30, 0);
    do_restart();
  endtask

  task automatic test_bad_checksum();
    word_q_t w;
    w = '{16'h0005, 16'h0002, 16'h0009};
    run_load(16'h3250, w, 1'b1, 8'h6E, 0);
    do_restart();
    run_load(16'h3250, w, 1'b1, 8'h6F, 0);
    do_restart();
  endtask

  task automatic test_timeout();
    wr_q.delete();
    send_byte(8'h32);
    send_byte(8'h50);
    idle(15);
    send_byte(8'h00);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL byte_beats_timeout: got error=%b want 0", error);
    end
    idle(15);
    checks++;
    if (error !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got error=%b cpu_reset=%b want 0 1", error, cpu_reset);
    end
    idle(1);
    checks++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_at_16: got error=%b cpu_reset=%b done=%b want 1 1 0", error, cpu_reset, done);
    end
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00); send_byte(8'h02);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL error_ignores_bytes: got error=%b done=%b writes=%0d want 1 0 0", error, done, wr_q.size());
    end
    do_restart();
  endtask

  task automatic test_async_reset();
    word_q_t w;
    wr_q.delete();
    send_byte(8'h32); send_byte(8'h50); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h00); send_byte(8'h05);
    checks++;
    if (wr_q.size() != 1) begin
      errors++;
      $display("FAIL pre_reset_write: got %0d writes want 1", wr_q.size());
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 16'h0 || mem_data !== 16'h0 || mem_we !== 1'b0 || cpu_reset !== 1'b1 ||
        start_pc !== 16'h0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got addr=%h data=%h we=%b cpu_reset=%b pc=%h done=%b error=%b",
               mem_addr, mem_data, mem_we, cpu_reset, start_pc, done, error);
    end
    @(negedge clk);
    wr_q.delete();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h09); send_byte(8'h6F);
    checks++;
    if (wr_q.size() != 0 || done !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL no_write_in_reset: got writes=%0d done=%b cpu_reset=%b want 0 0 1", wr_q.size(), done, cpu_reset);
    end
    rst_n = 1'b1;
    idle(1);
    w = '{16'h0005, 16'h0002, 16'h0009};
    run_load(16'h3250, w, 1'b1, 8'h6F, 0);
    do_restart();
  endtask

  task automatic test_random_loads();
    word_q_t     w;
    logic [15:0] org;
    int          n;
    for (int it = 0; it < 10; it++) begin
      org = (it % 3 == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      n   = $urandom_range(0, 6);
      w   = {};
      for (int k = 0; k < n; k++) w.push_back(16'($urandom));
      run_load(org, w, ($urandom_range(0, 2) == 0), 8'($urandom), 15);
      do_restart();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_load();
    test_ignored_bytes();
    test_restart_collision();
    test_addr_wrap();
    test_zero_count();
    test_bad_checksum();
    test_timeout();
    test_async_reset();
    test_random_loads();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
